// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: full-speed USB receive path. It synchronizes D+/D-,
// recovers bit timing from D+ edges, NRZI-decodes, checks SYNC, removes
// stuff bits, assembles bytes LSB first and flags end-of-packet.
// Optional feature macro: USB_RX_STUFF_CHECK_EN. When defined, a stuff bit
// that decodes as 1 aborts the packet with rx_error.
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SAMPLE_PT    = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  output logic [7:0] rx_data,
  output logic       byte_ready,
  output logic       packet_start,
  output logic       eop,
  output logic       rx_error,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_PT);

  typedef enum logic [1:0] {IDLE, SYNC, RECEIVE, EOP_WAIT} state_e;

  state_e          state_q, state_d;
  logic            dp_s1_q, dp_s2_q, dm_s1_q, dm_s2_q;
  logic            dp_prev_q, dm_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prev_lvl_q, prev_lvl_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      ones_q, ones_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            byte_ready_q, byte_ready_d;
  logic            packet_start_q, packet_start_d;
  logic            eop_q, eop_d;
  logic            rx_error_q, rx_error_d;
  logic            eop_pend_q, eop_pend_d;

  logic            line_k, line_se0, line_lvl, dp_edge, se0_det, j_twice;
  logic            bit_tick, dec_bit;
  logic [7:0]      shifted;

  // Two-flop synchronizers plus one history flop of the synchronized lines.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_s1_q   <= 1'b1;
      dp_s2_q   <= 1'b1;
      dm_s1_q   <= 1'b0;
      dm_s2_q   <= 1'b0;
      dp_prev_q <= 1'b1;
      dm_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop take its pre-edge
      // input, so the chain really is two stages deep.
      dp_s1_q   <= d_plus_in;
      dp_s2_q   <= dp_s1_q;
      dm_s1_q   <= d_minus_in;
      dm_s2_q   <= dm_s1_q;
      dp_prev_q <= dp_s2_q;
      dm_prev_q <= dm_s2_q;
    end
  end

  // J is any line with D+ high (covers the illegal 1,1 state).
  assign line_k   = ~dp_s2_q & dm_s2_q;
  assign line_se0 = ~dp_s2_q & ~dm_s2_q;
  assign line_lvl = dp_s2_q;
  assign dp_edge  = dp_s2_q ^ dp_prev_q;
  assign se0_det  = line_se0 & ~dp_prev_q & ~dm_prev_q;
  assign j_twice  = dp_s2_q & dp_prev_q;

  assign bit_tick = (cnt_q == CNT_SAMPLE) && !line_se0 &&
                    ((state_q == SYNC) || (state_q == RECEIVE));
  assign dec_bit  = (line_lvl == prev_lvl_q);
  assign shifted  = {dec_bit, shreg_q[7:1]};

  // Next-state logic: bit timing, NRZI decode, unstuffing and packet FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    prev_lvl_d     = prev_lvl_q;
    bit_cnt_d      = bit_cnt_q;
    ones_d         = ones_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    byte_ready_d   = 1'b0;
    packet_start_d = 1'b0;
    eop_d          = eop_pend_q;
    rx_error_d     = 1'b0;
    eop_pend_d     = 1'b0;

    if ((state_q == IDLE) || dp_edge || (cnt_q == CNT_LAST)) cnt_d = '0;
    else                                                     cnt_d = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        prev_lvl_d = 1'b1;
        bit_cnt_d  = 3'd0;
        ones_d     = 3'd0;
        shreg_d    = 8'h00;
        if (line_k) state_d = SYNC;
      end
      SYNC: begin
        if (se0_det) begin
          rx_error_d = 1'b1;
          state_d    = EOP_WAIT;
        end else if (bit_tick) begin
          prev_lvl_d = line_lvl;
          shreg_d    = shifted;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shifted == 8'h80) begin
              packet_start_d = 1'b1;
              ones_d         = 3'd0;
              state_d        = RECEIVE;
            end else begin
              rx_error_d = 1'b1;
              state_d    = EOP_WAIT;
            end
          end
        end
      end
      RECEIVE: begin
        if (bit_tick) begin
          prev_lvl_d = line_lvl;
          if (ones_q == 3'd6) begin
            ones_d = 3'd0;
`ifdef USB_RX_STUFF_CHECK_EN
            if (dec_bit) begin
              rx_error_d = 1'b1;
              state_d    = EOP_WAIT;
            end
`endif
          end else begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d    = shifted;
              byte_ready_d = 1'b1;
            end
          end
        end
        if (se0_det) begin
          state_d = EOP_WAIT;
          // A byte finishing in this cycle is reported first; eop follows.
          if (byte_ready_d) begin
            eop_pend_d = 1'b1;
          end else begin
            eop_d      = 1'b1;
            rx_error_d = (bit_cnt_d != 3'd0);
          end
        end
      end
      EOP_WAIT: begin
        if (j_twice) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoder state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      prev_lvl_q     <= 1'b1;
      bit_cnt_q      <= 3'd0;
      ones_q         <= 3'd0;
      shreg_q        <= 8'h00;
      rx_data_q      <= 8'h00;
      byte_ready_q   <= 1'b0;
      packet_start_q <= 1'b0;
      eop_q          <= 1'b0;
      rx_error_q     <= 1'b0;
      eop_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prev_lvl_q     <= prev_lvl_d;
      bit_cnt_q      <= bit_cnt_d;
      ones_q         <= ones_d;
      shreg_q        <= shreg_d;
      rx_data_q      <= rx_data_d;
      byte_ready_q   <= byte_ready_d;
      packet_start_q <= packet_start_d;
      eop_q          <= eop_d;
      rx_error_q     <= rx_error_d;
      eop_pend_q     <= eop_pend_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign byte_ready   = byte_ready_q;
  assign packet_start = packet_start_q;
  assign eop          = eop_q;
  assign rx_error     = rx_error_q;
  assign rx_busy      = (state_q != IDLE);

endmodule
